// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tristate bus arbiter family.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } arb_state_t;

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  sel,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        sel = '0;
        idx = '0;
        any = |req;
        // Walk from farthest to nearest so the nearest requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                sel = '0;
                sel[(int'(ptr) + k) % N] = 1'b1;
                idx = IW'((int'(ptr) + k) % N);
            end
        end
    end

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with hold limit and turnaround gap.
//   state    | meaning
//   ST_IDLE  | bus Z, arbitrating among req; grant lands on the next edge
//   ST_GRANT | owner drives bus, one beat per cycle with req[owner] high
//   ST_TURN  | bus Z for TURN cycles before arbitration resumes
module tristate_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_CH     = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4,
    parameter int TURN     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH-1:0]          req,
    input  logic [N_CH-1:0]          last,
    input  logic [N_CH*WIDTH-1:0]    din,
    output logic [N_CH-1:0]          gnt,
    output logic [idx_w(N_CH)-1:0]   owner,
    output logic                     busy,
    output tri   [WIDTH-1:0]         bus
);

    localparam int IW = idx_w(N_CH);
    localparam int HW = idx_w(MAX_HOLD + 1);
    localparam int TW = idx_w(TURN + 1);

    arb_state_t      state, state_n;
    logic [N_CH-1:0] gnt_n;
    logic [IW-1:0]   owner_n, ptr, ptr_n;
    logic            busy_n;
    logic [HW-1:0]   hold_left, hold_left_n;
    logic [TW-1:0]   turn_left, turn_left_n;

    logic [N_CH-1:0]  pick_sel;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;
    logic             own_req, own_last;
    logic [WIDTH-1:0] own_data;

    rr_pick #(.N(N_CH), .IW(IW)) u_pick (
        .req (req),
        .ptr (ptr),
        .sel (pick_sel),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        own_req  = 1'b0;
        own_last = 1'b0;
        own_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (owner == IW'(i)) begin
                own_req  = req[i];
                own_last = last[i];
                own_data = din[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            gnt       <= '0;
            owner     <= '0;
            busy      <= 1'b0;
            ptr       <= '0;
            hold_left <= '0;
            turn_left <= '0;
        end else begin
            state     <= state_n;
            gnt       <= gnt_n;
            owner     <= owner_n;
            busy      <= busy_n;
            ptr       <= ptr_n;
            hold_left <= hold_left_n;
            turn_left <= turn_left_n;
        end
    end

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        owner_n     = owner;
        busy_n      = busy;
        ptr_n       = ptr;
        hold_left_n = hold_left;
        turn_left_n = turn_left;
        unique case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_n     = ST_GRANT;
                    gnt_n       = pick_sel;
                    owner_n     = pick_idx;
                    busy_n      = 1'b1;
                    hold_left_n = HW'(MAX_HOLD);
                end
            end
            ST_GRANT: begin
                // hold_left counts beats still allowed, including this one.
                if (!own_req || own_last || hold_left == HW'(1)) begin
                    gnt_n       = '0;
                    busy_n      = 1'b0;
                    ptr_n       = (owner == IW'(N_CH - 1)) ? '0 : owner + 1'b1;
                    state_n     = (TURN > 0) ? ST_TURN : ST_IDLE;
                    turn_left_n = TW'((TURN > 0) ? TURN - 1 : 0);
                end else begin
                    hold_left_n = hold_left - 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_left == '0) begin
                    state_n = ST_IDLE;
                end else begin
                    turn_left_n = turn_left - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign bus = busy ? own_data : {WIDTH{1'bz}};

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench: two arbiters (TURN=1 and TURN=0) share stimulus, each
// checked against a cycle-level behavioural model of bus ownership.
module tb_tristate_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 4;

    logic           clk   = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N-1:0]   last  = '0;
    logic [N*W-1:0] din   = '0;

    logic [N-1:0] gnt1, gnt0;
    logic [1:0]   own1, own0;
    logic         busy1, busy0;
    wire  [W-1:0] bus1, bus0;

    always #5 clk = ~clk;

    tristate_bus_arbiter #(.N_CH(N), .WIDTH(W), .MAX_HOLD(MH), .TURN(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din),
        .gnt(gnt1), .owner(own1), .busy(busy1), .bus(bus1)
    );

    tristate_bus_arbiter #(.N_CH(N), .WIDTH(W), .MAX_HOLD(MH), .TURN(0)) u_dut_t0 (
        .clk(clk), .rst_n(rst_n), .req(req), .last(last), .din(din),
        .gnt(gnt0), .owner(own0), .busy(busy0), .bus(bus0)
    );

    typedef struct {
        logic [N-1:0] gnt;
        logic         busy;
        logic [1:0]   owner;
        logic [W-1:0] bus;
    } exp_t;

    // Model: who owns the bus, beats used, Z cycles still owed, priority start.
    typedef struct {
        bit busy;
        int own;
        int beats;
        int gap;
        int ptr;
    } mdl_t;

    exp_t q1[$];
    exp_t q0[$];
    mdl_t m1, m0;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t s;
        s.busy = 0; s.own = 0; s.beats = 0; s.gap = 0; s.ptr = 0;
        return s;
    endfunction

    function automatic exp_t expect_of(input mdl_t s, input logic [N*W-1:0] d);
        exp_t e;
        e.busy  = s.busy;
        e.owner = 2'(s.own);
        e.gnt   = s.busy ? N'(1 << s.own) : '0;
        e.bus   = s.busy ? d[s.own*W +: W] : {W{1'bz}};
        return e;
    endfunction

    function automatic mdl_t step(input mdl_t s, input int turn,
                                  input logic [N-1:0] r, input logic [N-1:0] l);
        bit rel;
        bit found;
        rel   = 0;
        found = 0;
        if (s.busy) begin
            if (!r[s.own]) rel = 1;
            else begin
                s.beats++;
                if (l[s.own] || s.beats == MH) rel = 1;
            end
            if (rel) begin
                s.busy = 0;
                s.ptr  = (s.own + 1) % N;
                s.gap  = turn;
            end
        end else if (s.gap > 0) begin
            s.gap--;
        end else if (r != '0) begin
            for (int k = 0; k < N; k++) begin
                if (!found && r[(s.ptr + k) % N]) begin
                    found = 1;
                    s.own = (s.ptr + k) % N;
                end
            end
            s.busy  = 1;
            s.beats = 0;
        end
        return s;
    endfunction

    function automatic logic [N*W-1:0] rnd();
        return $urandom;
    endfunction

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N*W-1:0] d);
        @(posedge clk);
        #1;
        req  = r;
        last = l;
        din  = d;
        q1.push_back(expect_of(m1, d));
        q0.push_back(expect_of(m0, d));
        m1 = step(m1, 1, r, l);
        m0 = step(m0, 0, r, l);
    endtask

    task automatic reset_mid_grant();
        for (int i = 0; i < 10 && !(m1.busy && m1.own == 2); i++) cycle(4'b0100, '0, rnd());
        cycle(4'b0100, '0, rnd());
        @(negedge clk);
        #2;
        check("pre_reset_busy", {31'b0, busy1}, 32'd1);
        check("pre_reset_gnt", {28'b0, gnt1}, 32'h4);
        rst_n = 1'b0;
        req   = '0;
        last  = '0;
        #1;
        check("rst_bus_t1", {24'b0, bus1}, {24'b0, {W{1'bz}}});
        check("rst_gnt_t1", {28'b0, gnt1}, 32'h0);
        check("rst_busy_t1", {31'b0, busy1}, 32'h0);
        check("rst_bus_t0", {24'b0, bus0}, {24'b0, {W{1'bz}}});
        check("rst_gnt_t0", {28'b0, gnt0}, 32'h0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        m1 = mdl_reset();
        m0 = mdl_reset();
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            check("onehot_t1", {31'b0, ($countones(gnt1) <= 1)}, 32'd1);
            check("onehot_t0", {31'b0, ($countones(gnt0) <= 1)}, 32'd1);
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("gnt_t1",   {28'b0, gnt1},  {28'b0, e.gnt});
                check("busy_t1",  {31'b0, busy1}, {31'b0, e.busy});
                check("owner_t1", {30'b0, own1},  {30'b0, e.owner});
                check("bus_t1",   {24'b0, bus1},  {24'b0, e.bus});
            end
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("gnt_t0",   {28'b0, gnt0},  {28'b0, e.gnt});
                check("busy_t0",  {31'b0, busy0}, {31'b0, e.busy});
                check("owner_t0", {30'b0, own0},  {30'b0, e.owner});
                check("bus_t0",   {24'b0, bus0},  {24'b0, e.bus});
            end
        end
    end

    initial begin : stimulus
        logic [N*W-1:0] d;
        m1 = mdl_reset();
        m0 = mdl_reset();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;

        // single burst from ch0, last on the third beat
        d = rnd();
        d[7:0] = 8'hA5;
        cycle(4'b0001, 4'b0000, d);
        cycle(4'b0001, 4'b0000, d);
        cycle(4'b0001, 4'b0000, d);
        cycle(4'b0001, 4'b0001, d);
        repeat (3) cycle('0, '0, rnd());

        // ch1 never signals last: hold limit forces release and regrant
        repeat (14) cycle(4'b0010, '0, rnd());
        repeat (3) cycle('0, '0, rnd());

        // all channels, single-beat bursts
        repeat (20) cycle(4'b1111, 4'b1111, rnd());
        repeat (3) cycle('0, '0, rnd());

        // ch3 releases while ch0 and ch3 request: rotation wraps to ch0
        for (int i = 0; i < 8 && !(m1.busy && m1.own == 3); i++) cycle(4'b1000, '0, rnd());
        cycle(4'b1001, 4'b1000, rnd());
        repeat (8) cycle(4'b1001, 4'b1001, rnd());
        repeat (3) cycle('0, '0, rnd());

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(N'($urandom_range(0, 15)), N'($urandom) & N'($urandom), rnd());
        end
        repeat (3) cycle('0, '0, rnd());

        reset_mid_grant();
        repeat (4) cycle('0, '0, rnd());
        repeat (6) cycle(4'b0101, 4'b0000, rnd());

        repeat (2) @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
